// File: rtl/step_counter_param_if.sv
// Control/status bundle for step_counter_param.
// The master side drives the count controls. The slave side (the counter)
// returns the count, the terminal-count pulse and the sticky overflow flag.
interface step_counter_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] limit;
  logic             clear_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output enable, load, d, dir, sat, limit, clear_ovf,
    input  q, tc, ovf
  );

  modport slave (
    input  enable, load, d, dir, sat, limit, clear_ovf,
    output q, tc, ovf
  );
endinterface

// File: rtl/step_counter_param.sv
// step_counter_param: parametrised up/down step counter.
// - Counts in the range [0, limit].
// - Supports parallel load, with the loaded value clamped to limit.
// - Wraps or saturates at either bound.
// - Raises a one-cycle terminal-count pulse on each crossing step.
// - Keeps a sticky overflow flag that is set by wrap events.
// Optional feature: define COUNTER_PRESCALE_EN to take one step every
// PRESCALE enabled cycles.
module step_counter_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP     = 2,
  parameter int unsigned PRESCALE = 4
) (
  input logic                 clk,
  input logic                 reset,
  step_counter_param_if.slave bus
);

  localparam int unsigned SW = WIDTH + 1;
  localparam logic [SW-1:0]    STEP_X = SW'(STEP);
  localparam logic [WIDTH-1:0] STEP_Q = WIDTH'(STEP);

  logic [WIDTH-1:0] q_r, q_n;
  logic             tc_r, tc_n;
  logic             ovf_r, ovf_n;
  logic             wrap;
  logic             step_go;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    lim_x;
  logic [SW-1:0]    q_x;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_r, ps_n;
  logic          ps_hit;

  // Prescaler: counts enabled cycles; a load or a terminal hit restarts it.
  always_comb begin
    ps_n   = ps_r;
    ps_hit = (ps_r == PS_LAST);
    if (bus.load) begin
      ps_n = '0;
    end else if (bus.enable) begin
      ps_n = ps_hit ? '0 : ps_r + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_r <= '0;
    end else begin
      ps_r <= ps_n;
    end
  end

  assign step_go = bus.enable & ps_hit;
`else
  logic unused_prescale;
  assign unused_prescale = |PRESCALE;
  assign step_go         = bus.enable;
`endif

  assign q_x   = {1'b0, q_r};
  assign lim_x = {1'b0, bus.limit};
  // The sum carries one extra bit so that a crossing at the top of the range is never lost.
  assign sum   = q_x + STEP_X;

  // Next count, terminal-count pulse and wrap detection.
  always_comb begin
    q_n  = q_r;
    tc_n = 1'b0;
    wrap = 1'b0;
    if (bus.load) begin
      q_n = (bus.d <= bus.limit) ? bus.d : bus.limit;
    end else if (step_go) begin
      if (bus.dir) begin
        if (sum <= lim_x) begin
          q_n = sum[WIDTH-1:0];
        end else begin
          tc_n = 1'b1;
          if (bus.sat) begin
            q_n = bus.limit;
          end else begin
            q_n  = '0;
            wrap = 1'b1;
          end
        end
      end else begin
        if (q_x >= STEP_X) begin
          q_n = q_r - STEP_Q;
        end else begin
          tc_n = 1'b1;
          if (bus.sat) begin
            q_n = '0;
          end else begin
            q_n  = bus.limit;
            wrap = 1'b1;
          end
        end
      end
    end
  end

  // Sticky overflow: a wrap in the same cycle as a clear takes priority.
  assign ovf_n = wrap | (ovf_r & ~bus.clear_ovf);

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_n;
      tc_r  <= tc_n;
      ovf_r <= ovf_n;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_step_counter_param.sv
// Self-checking bench for step_counter_param (WIDTH=8, STEP=2, PRESCALE=4).
// Runs the directed scenarios first, then random stimulus, and compares the
// DUT against an integer reference model.
module tb_step_counter_param;

  localparam int unsigned WIDTH    = 8;
  localparam int          STEP     = 2;
  localparam int          PRESCALE = 4;

  logic clk;
  logic reset;

  step_counter_param_if #(.WIDTH(WIDTH)) bus ();

  step_counter_param #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int mq;
  int mtc;
  int movf;
  int mps;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mq   = 0;
    mtc  = 0;
    movf = 0;
    mps  = 0;
  endtask

  // Apply the counter rules to the current inputs, giving the state after the next edge.
  task automatic model_step();
    int lim;
    int s;
    bit wrap;
    bit go;
    lim  = int'(bus.limit);
    wrap = 1'b0;
    mtc  = 0;
    if (bus.load) begin
      mq  = (int'(bus.d) <= lim) ? int'(bus.d) : lim;
      mps = 0;
    end else if (bus.enable) begin
`ifdef COUNTER_PRESCALE_EN
      mps++;
      go = (mps == PRESCALE);
      if (go) mps = 0;
`else
      go = 1'b1;
`endif
      if (go) begin
        if (bus.dir) begin
          s = mq + STEP;
          if (s <= lim) mq = s;
          else if (bus.sat) begin mq = lim; mtc = 1; end
          else begin mq = 0; mtc = 1; wrap = 1'b1; end
        end else begin
          if (mq >= STEP) mq = mq - STEP;
          else if (bus.sat) begin mq = 0; mtc = 1; end
          else begin mq = lim; mtc = 1; wrap = 1'b1; end
        end
      end
    end
    if (wrap) movf = 1;
    else if (bus.clear_ovf) movf = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},   int'(bus.q),   mq);
    check({tag, ".tc"},  int'(bus.tc),  mtc);
    check({tag, ".ovf"}, int'(bus.ovf), movf);
  endtask

  task automatic drive(input bit en, input bit ld, input int dv, input bit dr,
                       input bit st, input int lim, input bit clr);
    bus.enable    = en;
    bus.load      = ld;
    bus.d         = WIDTH'(dv);
    bus.dir       = dr;
    bus.sat       = st;
    bus.limit     = WIDTH'(lim);
    bus.clear_ovf = clr;
  endtask

  // One clock edge. Outputs are sampled 1 ns after the edge and compared with the model.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Pulse reset between clock edges and check that the outputs clear without an edge.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    #1;
    reset = 1'b0;
  endtask

  // Explicit expectations for the default build, where every enabled cycle steps.
  task automatic expect_out(input string tag, input int q, input int tc, input int ovf);
`ifndef COUNTER_PRESCALE_EN
    check({tag, ".q"},   int'(bus.q),   q);
    check({tag, ".tc"},  int'(bus.tc),  tc);
    check({tag, ".ovf"}, int'(bus.ovf), ovf);
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 1, 0, 255, 0);
    model_reset();
    #12;
    check_model("rst");
    reset = 1'b0;

    // 1: count up to 70, reset mid-cycle, then restart counting from 0.
    for (int i = 0; i < 35; i++) tick("t1.up");
`ifndef COUNTER_PRESCALE_EN
    drive(1, 0, 0, 1, 0, 255, 0);
    for (int i = 0; i < 35; i++) tick("t1.up");
    expect_out("t1.at70", 70, 0, 0);
`endif
    reset_pulse("t1.rst");
    drive(1, 0, 0, 1, 0, 255, 0);
    tick("t1.c2");
    expect_out("t1.c2x", 2, 0, 0);
    tick("t1.c4");
    expect_out("t1.c4x", 4, 0, 0);

    // 2: a load wins over enable; a load value above the limit is clamped.
    drive(1, 1, 160, 1, 0, 255, 0);
    tick("t2.ld");
    expect_out("t2.ldx", 160, 0, 0);
    drive(0, 1, 250, 1, 0, 200, 0);
    tick("t2.clamp");
    expect_out("t2.clampx", 200, 0, 0);

    // 3: wrap at the upper limit, then clear_ovf.
    drive(0, 1, 198, 1, 0, 200, 0);
    tick("t3.ld");
    drive(1, 0, 0, 1, 0, 200, 0);
    tick("t3.s1");
    expect_out("t3.s1x", 200, 0, 0);
    tick("t3.wrap");
    expect_out("t3.wrapx", 0, 1, 1);
    drive(0, 0, 0, 1, 0, 200, 1);
    tick("t3.clr");
    expect_out("t3.clrx", 0, 0, 0);

    // 4: saturate at 255; tc pulses again while held at the bound.
    drive(0, 1, 252, 1, 1, 255, 0);
    tick("t4.ld");
    drive(1, 0, 0, 1, 1, 255, 0);
    tick("t4.s1");
    expect_out("t4.s1x", 254, 0, 0);
    tick("t4.s2");
    expect_out("t4.s2x", 255, 1, 0);
    tick("t4.s3");
    expect_out("t4.s3x", 255, 1, 0);

    // 5: down wrap below zero together with clear_ovf; the set wins.
    drive(0, 1, 1, 0, 0, 100, 0);
    tick("t5.ld");
    drive(1, 0, 0, 0, 0, 100, 1);
    tick("t5.wrap");
    expect_out("t5.wrapx", 100, 1, 1);

`ifdef COUNTER_PRESCALE_EN
    // 6: one step every PRESCALE enabled cycles; a load restarts the prescale count.
    reset_pulse("t6.rst");
    drive(1, 0, 0, 1, 0, 255, 0);
    for (int i = 1; i <= 8; i++) begin
      tick("t6.ps");
      if (i == 4) check("t6.q4", int'(bus.q), 2);
      if (i == 8) check("t6.q8", int'(bus.q), 4);
    end
    drive(1, 0, 0, 1, 0, 255, 0);
    tick("t6.pre");
    tick("t6.pre");
    drive(1, 1, 10, 1, 0, 255, 0);
    tick("t6.ld");
    drive(1, 0, 0, 1, 0, 255, 0);
    for (int i = 1; i <= 4; i++) begin
      tick("t6.after");
      if (i == 3) check("t6.hold", int'(bus.q), 10);
      if (i == 4) check("t6.step", int'(bus.q), 12);
    end
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 70,
            $urandom_range(99) < 8,
            int'($urandom_range(255)),
            $urandom_range(1),
            $urandom_range(1),
            ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(255, 180)),
            $urandom_range(99) < 10);
      tick("rnd");
      if ($urandom_range(99) < 2) reset_pulse("rnd.rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
